fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch front end of the RV32I 5-stage pipeline.
- Owns the program counter and issues sequential word fetches to the instruction memory.
- Buffers returned instructions with their PCs in a small in-order queue.
- Presents {pc, instr} to the IF/ID register over a valid/ready handshake.
- Accepts a branch/jump redirect from the EX/MEM stage, flushes wrong-path work and restarts fetch at the target.

Parameters:
XLEN, 32, address/data width.
DEPTH, 4, queue entries; power of 2, >= 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
redirect_valid  in  1  taken branch/jump resolved this cycle.
redirect_pc  in  XLEN  redirect target.
imem_req  out  1  fetch request this cycle.
imem_addr  out  XLEN  fetch address, word-aligned.
imem_rvalid  in  1  response valid; asserted exactly 1 cycle after imem_req.
imem_rdata  in  32  instruction word.
out_valid  out  1  queue head valid to IF/ID.
out_ready  in  1  IF/ID accepts (low = decode stall).
out_pc  out  XLEN  PC of head instruction.
out_instr  out  32  head instruction.

Behaviour:
- Reset (rst=0, async):
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0.
  - Queue empty, inflight=0, fetch_pc=RESET_PC.
- State:
  - fetch_pc: next address to fetch.
  - count: 0..DEPTH, queue occupancy.
  - inflight: 0/1, a request was issued last cycle and not killed.
  - Queue holds {pc, instr}.
- Issue rule: imem_req=1 when count + inflight < DEPTH, or when redirect_valid=1. Pops in the current cycle are not credited.
  - Normal issue: imem_addr=fetch_pc; fetch_pc <= fetch_pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
  - Redirect cycle: imem_addr=redirect_pc; fetch_pc <= redirect_pc+4. Zero-bubble restart.
- Response: imem_rvalid pushes {pc of matching request, imem_rdata} into the queue tail. The request PC is registered at issue.
- Output:
  - out_valid = (count != 0) and not redirect_valid.
  - out_pc/out_instr come combinationally from the queue head.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are allowed, including at count==DEPTH-1.
  - The issue rule guarantees no push while full.
- Throughput: 1 instr/cycle sustained with out_ready=1. First instruction is visible 2 cycles after the issuing cycle.
- Redirect (priority over all other events):
  - Queue cleared (count<=0).
  - Any imem_rvalid in the same cycle is discarded.
  - No pop occurs and out_valid is forced to 0.
  - inflight <= 1 for the new redirect request.
- redirect_pc[1:0] != 0: low bits are forced to 00.
- Back-to-back redirects: each one discards the previous cycle's request.
- out_ready low indefinitely: queue fills to DEPTH, then imem_req stays 0. pc/instr at the head are held stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation: all state returns to reset values immediately. Responses arriving while or right after rst=0 are dropped (inflight=0).

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds outputs perf_fetched (32-bit, increments on each pop) and perf_flushed (32-bit, adds count plus the discarded response on each redirect).
  - Both counters reset to 0 and saturate at 0xFFFF_FFFF.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - XLEN, ILEN=32, PC_STEP=4.
  - fetch_entry_t typedef {pc, instr}.
  - NOP_INSTR=32'h0000_0013.
- Sub-module fetch_fifo:
  - Parameterised DEPTH and width.
  - Push, pop and flush ports; count output.
  - Head data output, combinational.
  - Pointers wrap modulo DEPTH.
- fetch_unit holds the PC, the issue/credit logic and the redirect control.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> out_valid=0, imem_req=0. First cycle after release: imem_req=1, imem_addr=0x0. out_valid rises 2 cycles later with out_pc=0x0.
- Streaming: memory returns addr-based words, out_ready=1 -> out_pc 0,4,8,C... on consecutive cycles with no bubbles.
- Backpressure: out_ready=0 -> exactly 4 requests (0x0..0xC), then imem_req=0. Raise out_ready -> pops 0,4,8,C in order and fetch resumes at 0x10.
- Redirect mid-stream to 0x100 while full and a response is arriving -> that response is dropped and out_valid=0 in the redirect cycle. The next out_pc sequence is 0x100, 0x104 with no stale PCs.
- Wrap-around: redirect to 0xFFFF_FFF8 -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Reset asserted with queue half full and a request in flight -> all outputs return to reset values at once. The late imem_rvalid is ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch front end.
// Used by fetch_fifo and fetch_unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order queue of fetched {pc, instr} entries.
// Combinational head output; flush empties the queue in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Storage write; entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, issue credit and redirect control for IF.
// Optional FETCH_PERF_EN adds perf_fetched/perf_flushed counters.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] target;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     credit;
  logic            redir;
  logic            push;
  logic            pop;
  logic            busy;
  fetch_entry_t    head;
  fetch_entry_t    tail;

  // Issue credit: queued plus in-flight must leave a free slot.
  always_comb begin
    target    = {redirect_pc[XLEN-1:2], 2'b00};
    redir     = rst & redirect_valid;
    credit    = {1'b0, count} + {{CW{1'b0}}, inflight};
    imem_req  = rst & (redirect_valid |
                       (credit < (CW+1)'(DEPTH)));
    imem_addr = redir ? target : fetch_pc;
    busy      = (count != '0);
    push      = imem_rvalid & inflight & ~redirect_valid;
    out_valid = busy & ~redirect_valid;
    pop       = out_valid & out_ready;
    tail.pc   = req_pc;
    tail.instr = imem_rdata;
    out_pc    = busy ? head.pc : '0;
    out_instr = busy ? head.instr : '0;
  end

  // PC advance and record of the outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        req_pc   <= imem_addr;
        fetch_pc <= imem_addr + XLEN'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (tail),
    .dout  (head),
    .count (count)
  );

`ifdef FETCH_PERF_EN
  // Saturating counters for delivered and squashed instructions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop)
        perf_fetched <= sat_add(perf_fetched, 32'd1);
      if (redir)
        perf_flushed <= sat_add(perf_flushed,
          32'(count) + 32'(imem_rvalid & inflight));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus for fetch_unit,
// checked against a queue-based reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: answers every request one cycle later.
  always @(posedge clk) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= word_at(imem_addr);
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  localparam int QD = 4;

  ent_t        q[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_fpc;
  bit          e_req;
  bit          e_valid;
  logic [31:0] e_addr;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_infl    = 1'b0;
    m_infl_pc = '0;
    m_fpc     = '0;
  endtask

  task automatic check_reset_outs();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
  endtask

  // One clock: compare at negedge, advance model at posedge.
  task automatic cycle();
    logic [31:0] tgt;
    @(negedge clk);
    tgt = redirect_pc & 32'hFFFF_FFFC;
    if (!rst) begin
      check_reset_outs();
    end else begin
      e_req = redirect_valid ||
              (q.size() + int'(m_infl) < QD);
      e_addr = redirect_valid ? tgt : m_fpc;
      e_valid = (q.size() != 0) && !redirect_valid;
      chk("req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("addr", imem_addr, e_addr);
      chk("valid", 32'(out_valid), 32'(e_valid));
      if (e_valid) begin
        chk("pc", out_pc, q[0].pc);
        chk("instr", out_instr, q[0].instr);
      end
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (redirect_valid) begin
      q.delete();
      m_infl    = 1'b1;
      m_infl_pc = tgt;
      m_fpc     = tgt + 32'd4;
    end else begin
      if (e_valid && out_ready) void'(q.pop_front());
      if (m_infl)
        q.push_back('{m_infl_pc, word_at(m_infl_pc)});
      if (q.size() > QD) begin
        fails++;
        $display("FAIL overflow: size %0d", q.size());
      end
      m_infl = e_req;
      if (e_req) begin
        m_infl_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int guard;
    int reqs;
    model_reset();
    // Reset held for three cycles.
    run(3);
    rst = 1'b1;
    // First fetch from the reset PC, then streaming.
    run(12);
    // Backpressure: queue fills, then requests stop.
    out_ready = 1'b0;
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (e_req) reqs++;
    end
    chk("bp_stall_req", 32'(imem_req), 32'd0);
    out_ready = 1'b1;
    run(8);
    // Fill again and redirect while a response arrives.
    out_ready = 1'b0;
    guard = 0;
    while (!(m_infl && q.size() == QD - 1) && guard < 20) begin
      cycle();
      guard++;
    end
    chk("fill_guard", 32'(guard < 20), 32'd1);
    redirect_to(32'h0000_0100);
    out_ready = 1'b1;
    run(6);
    // Wrap-around through the top of the address space.
    redirect_to(32'hFFFF_FFF8);
    run(6);
    // Back-to-back redirects, second with unaligned low bits.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    cycle();
    redirect_pc    = 32'h0000_0303;
    cycle();
    redirect_valid = 1'b0;
    run(6);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    // Reset mid-operation with entries queued and one in flight.
    redirect_to(32'h0000_0400);
    out_ready = 1'b0;
    run(2);
    chk("pre_rst_infl", 32'(m_infl), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_outs();
    run(2);
    rst = 1'b1;
    out_ready = 1'b1;
    run(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
